// File: rtl/cpu_pkg.sv
// Shared types and sizes for the physical-register release path.
// Holds preg index width, pool size, commit width and the x0 preg.
package cpu_pkg;

    localparam int PREG_W    = 6;
    localparam int NUM_PREG  = 1 << PREG_W;
    localparam int COMMIT_W  = 2;
    localparam int REL_DEPTH = 8;

    typedef logic [PREG_W-1:0] preg_t;

    // p0 backs x0 and never returns to the free pool
    localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_release_unit_if.sv
// Commit-side and free-pool-side signals of the release unit.
// master: ROB/free-pool side (testbench); slave: release unit.
interface preg_release_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = PREG_W
);

    logic [COMMIT_W-1:0] commit_valid;
    logic [COMMIT_W-1:0] commit_has_rd;
    logic [WIDTH-1:0]    commit_old_preg0;
    logic [WIDTH-1:0]    commit_old_preg1;
    logic                commit_ready;
    logic                fp_full;
    logic                fp_push;
    logic [WIDTH-1:0]    fp_data;

    modport master (
        output commit_valid,
        output commit_has_rd,
        output commit_old_preg0,
        output commit_old_preg1,
        output fp_full,
        input  commit_ready,
        input  fp_push,
        input  fp_data
    );

    modport slave (
        input  commit_valid,
        input  commit_has_rd,
        input  commit_old_preg0,
        input  commit_old_preg1,
        input  fp_full,
        output commit_ready,
        output fp_push,
        output fp_data
    );

endinterface

// File: rtl/release_fifo.sv
// Two-write / one-read circular buffer of freed preg indices.
// Ports: clk, rst_n (sync, active-low); wr_cnt entries of wr_data0/1;
// rd_en pops the head; rd_data is the head; count is occupancy.
module release_fifo
    import cpu_pkg::*;
#(
    parameter  int WIDTH = PREG_W,
    parameter  int DEPTH = REL_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       wr_cnt,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // wr_data0 is always the older entry, already compacted
        if (wr_cnt != 2'd0) begin
            mem_d[wr_ptr_q] = wr_data0;
        end
        if (wr_cnt == 2'd2) begin
            mem_d[wr_ptr_q + PTR_W'(1)] = wr_data1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        count_d  = count_q + CNT_W'(wr_cnt) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/preg_release_unit.sv
// Write side of the preg free pool: queues old pregs from dual commit
// and pushes one per cycle to the free pool.
// Ports: clk, rst_n (sync, active-low); bus (commit + fp handshake);
// pending (occupancy); overflow_err, dfree_err (sticky until reset).
module preg_release_unit
    import cpu_pkg::*;
#(
    parameter  int WIDTH = PREG_W,
    parameter  int DEPTH = REL_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int NP    = 1 << WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    preg_release_unit_if.slave   bus,
    output logic [CNT_W-1:0]     pending,
    output logic                 overflow_err,
    output logic                 dfree_err
);

    logic             enq0, enq1;
    logic             acc0, acc1;
    logic             ready;
    logic             ovf_hit;
    logic             dup;
    logic             push;
    logic [1:0]       n_enq;
    logic [WIDTH-1:0] p0, p1;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] count;

    logic [NP-1:0]    pend_vec_q, pend_vec_d;
    logic             ovf_q, ovf_d;
    logic             dfree_q, dfree_d;

    assign p0 = bus.commit_old_preg0;
    assign p1 = bus.commit_old_preg1;

    always_comb begin
        enq0 = bus.commit_valid[0] & bus.commit_has_rd[0]
             & (p0 != WIDTH'(PREG_ZERO));
        enq1 = bus.commit_valid[1] & bus.commit_has_rd[1]
             & (p1 != WIDTH'(PREG_ZERO));
        ready   = (count <= CNT_W'(DEPTH - 2));
        ovf_hit = (|bus.commit_valid) & ~ready;
        // a commit while not ready is dropped whole
        acc0  = enq0 & ready;
        acc1  = enq1 & ready;
        n_enq = {1'b0, acc0} + {1'b0, acc1};
        // compact so the older surviving lane lands first
        e0    = acc0 ? p0 : p1;
        // gated by rst_n so a reset mid-drain never pushes
        push  = rst_n & (count != '0) & ~bus.fp_full;
    end

    release_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_cnt   (n_enq),
        .wr_data0 (e0),
        .wr_data1 (p1),
        .rd_en    (push),
        .rd_data  (head),
        .count    (count)
    );

    always_comb begin
        pend_vec_d = pend_vec_q;
        dup        = 1'b0;
        if (acc0 && pend_vec_q[p0]) dup = 1'b1;
        if (acc1 && pend_vec_q[p1]) dup = 1'b1;
        if (acc0 && acc1 && (p0 == p1)) dup = 1'b1;
        if (push) pend_vec_d[head] = 1'b0;
        if (acc0) pend_vec_d[p0] = 1'b1;
        if (acc1) pend_vec_d[p1] = 1'b1;
        ovf_d   = ovf_q | ovf_hit;
        dfree_d = dfree_q | dup;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vec_q <= '0;
            ovf_q      <= 1'b0;
            dfree_q    <= 1'b0;
        end else begin
            pend_vec_q <= pend_vec_d;
            ovf_q      <= ovf_d;
            dfree_q    <= dfree_d;
        end
    end

    assign bus.commit_ready = ready;
    assign bus.fp_push      = push;
    assign bus.fp_data      = push ? head : '0;
    assign pending          = count;
    assign overflow_err     = ovf_q;
    assign dfree_err        = dfree_q;

endmodule
